// File: rtl/button_pkg.sv
// Shared FSM state encoding, timer width and ms-to-cycle conversion for the gesture decoder.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package button_pkg;

  localparam int TIMER_W = 32;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    PRESSED     = 3'd1,
    LONG_HELD   = 3'd2,
    WAIT_SECOND = 3'd3,
    SECOND_HELD = 3'd4
  } state_t;

  // 64-bit intermediate so freq*ms cannot overflow before the divide
  function automatic logic [TIMER_W-1:0] ms_to_cycles(input int unsigned freq_hz,
                                                      input int unsigned ms);
    return TIMER_W'((64'(freq_hz) * 64'(ms)) / 64'd1000);
  endfunction

endpackage

// File: rtl/button_gesture_decoder_press_timer.sv
// Saturating cycle counter with synchronous clear and a terminal-count compare.
// Latency: count updates one cycle after enable; at_limit is combinational on count.
// Backpressure: none; holds at all-ones instead of wrapping.
module press_timer
  import button_pkg::*;
(
  input  logic               i_Clk,
  input  logic               i_Reset,
  input  logic               clear,
  input  logic               enable,
  input  logic [TIMER_W-1:0] limit,
  output logic [TIMER_W-1:0] count,
  output logic               at_limit
);

  always_ff @(posedge i_Clk) begin
    if (i_Reset || clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  assign at_limit = (count == limit);

endmodule

// File: rtl/button_gesture_decoder.sv
// Turns a debounced button level into press/short/double/long pulses (auto-repeat under BUTTON_REPEAT_EN).
// Latency: all outputs registered; each pulse lands one cycle after the deciding input cycle.
// Backpressure: none; pulses are one cycle wide and must be sampled every cycle.
module button_gesture_decoder
  import button_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ_HZ   = 25_000_000,
  parameter int unsigned LONG_PRESS_MS   = 1000,
  parameter int unsigned DOUBLE_CLICK_MS = 250,
  parameter int unsigned REPEAT_MS       = 200
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Switch,
  output logic o_Press,
  output logic o_Short,
  output logic o_Double,
  output logic o_Long,
  output logic o_Held,
  output logic o_Repeat
);

  // Terminal timer values: the decision is taken on the LIMIT-th cycle spent in a state
  localparam logic [TIMER_W-1:0] LONG_TERM =
    ms_to_cycles(CLOCK_FREQ_HZ, LONG_PRESS_MS) - 32'd1;
  localparam logic [TIMER_W-1:0] DOUBLE_TERM =
    ms_to_cycles(CLOCK_FREQ_HZ, DOUBLE_CLICK_MS) - 32'd1;
  localparam logic [TIMER_W-1:0] REPEAT_TERM =
    ms_to_cycles(CLOCK_FREQ_HZ, REPEAT_MS) - 32'd1;

  state_t state;
  state_t state_next;

  logic r_Prev;
  logic r_Armed;
  logic rise;
  logic fall;

  logic               timer_clear;
  logic               timer_en;
  logic [TIMER_W-1:0] timer_limit;
  logic [TIMER_W-1:0] timer_count;
  logic               timer_at_limit;

  logic short_nxt;
  logic double_nxt;
  logic long_nxt;
`ifdef BUTTON_REPEAT_EN
  logic repeat_nxt;
  logic repeat_reload;
`endif

  // r_Armed blocks a phantom rise when the button is already held as reset releases
  assign rise = i_Switch & ~r_Prev & r_Armed;
  assign fall = ~i_Switch & r_Prev;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_Prev  <= 1'b0;
      r_Armed <= ~i_Switch;
    end else begin
      r_Prev <= i_Switch;
      if (!i_Switch) begin
        r_Armed <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    timer_en    = 1'b0;
    timer_limit = LONG_TERM;
    short_nxt   = 1'b0;
    double_nxt  = 1'b0;
    long_nxt    = 1'b0;
`ifdef BUTTON_REPEAT_EN
    repeat_nxt    = 1'b0;
    repeat_reload = 1'b0;
`endif

    case (state)
      IDLE: begin
        if (rise) begin
          state_next = PRESSED;
        end
      end

      PRESSED: begin
        timer_en    = 1'b1;
        timer_limit = LONG_TERM;
        // a release on the threshold cycle still counts as a click
        if (fall) begin
          state_next = WAIT_SECOND;
        end else if (timer_at_limit && i_Switch) begin
          long_nxt   = 1'b1;
          state_next = LONG_HELD;
        end
      end

      LONG_HELD: begin
        timer_limit = REPEAT_TERM;
        if (fall) begin
          state_next = IDLE;
        end
`ifdef BUTTON_REPEAT_EN
        else begin
          timer_en = 1'b1;
          if (timer_at_limit) begin
            repeat_nxt    = 1'b1;
            repeat_reload = 1'b1;
          end
        end
`endif
      end

      WAIT_SECOND: begin
        timer_en    = 1'b1;
        timer_limit = DOUBLE_TERM;
        // window includes the expiry cycle, so a rise there beats the short click
        if (rise && (timer_count <= DOUBLE_TERM)) begin
          double_nxt = 1'b1;
          state_next = SECOND_HELD;
        end else if (timer_at_limit) begin
          short_nxt  = 1'b1;
          state_next = IDLE;
        end
      end

      SECOND_HELD: begin
        if (fall) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

`ifdef BUTTON_REPEAT_EN
  assign timer_clear = (state_next != state) | repeat_reload;
`else
  assign timer_clear = (state_next != state);
`endif

  press_timer u_press_timer (
    .i_Clk    (i_Clk),
    .i_Reset  (i_Reset),
    .clear    (timer_clear),
    .enable   (timer_en),
    .limit    (timer_limit),
    .count    (timer_count),
    .at_limit (timer_at_limit)
  );

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      o_Press  <= 1'b0;
      o_Short  <= 1'b0;
      o_Double <= 1'b0;
      o_Long   <= 1'b0;
      o_Held   <= 1'b0;
    end else begin
      o_Press  <= rise;
      o_Short  <= short_nxt;
      o_Double <= double_nxt;
      o_Long   <= long_nxt;
      o_Held   <= i_Switch;
    end
  end

`ifdef BUTTON_REPEAT_EN
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      o_Repeat <= 1'b0;
    end else begin
      o_Repeat <= repeat_nxt;
    end
  end
`else
  assign o_Repeat = 1'b0;
`endif

endmodule

// File: tb/tb_button_gesture_decoder.sv
// Bench for button_gesture_decoder at limits LONG=10, DOUBLE=5, REPEAT=4 cycles.
// Directed gesture scenarios plus random press/gap sequences scored against a run-length model.
module tb_button_gesture_decoder;

  localparam int LONG = 10;
  localparam int DBL  = 5;
  localparam int REP  = 4;
  localparam int MAXC = 600;

  logic i_Clk = 1'b0;
  logic i_Reset;
  logic i_Switch;
  logic o_Press, o_Short, o_Double, o_Long, o_Held, o_Repeat;

  always #5 i_Clk = ~i_Clk;

  button_gesture_decoder #(
    .CLOCK_FREQ_HZ   (1000),
    .LONG_PRESS_MS   (10),
    .DOUBLE_CLICK_MS (5),
    .REPEAT_MS       (4)
  ) dut (
    .i_Clk    (i_Clk),
    .i_Reset  (i_Reset),
    .i_Switch (i_Switch),
    .o_Press  (o_Press),
    .o_Short  (o_Short),
    .o_Double (o_Double),
    .o_Long   (o_Long),
    .o_Held   (o_Held),
    .o_Repeat (o_Repeat)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // stimulus per cycle; ob_* at index c is what the outputs show during cycle c
  logic lvl [MAXC];
  logic rst [MAXC];
  int   n;
  logic ob_press [MAXC], ob_short [MAXC], ob_double [MAXC];
  logic ob_long [MAXC], ob_rep [MAXC], ob_held [MAXC];
  logic ex_press [MAXC], ex_short [MAXC], ex_double [MAXC];
  logic ex_long [MAXC], ex_rep [MAXC];

  task automatic clear_stim();
    for (int i = 0; i < MAXC; i++) begin
      lvl[i] = 1'b0;
      rst[i] = 1'b0;
    end
    n = 0;
  endtask

  task automatic add_seg(input logic v, input int len);
    for (int i = 0; i < len; i++) begin
      lvl[n] = v;
      n++;
    end
  endtask

  task automatic run_stim();
    i_Reset  = 1'b1;
    i_Switch = 1'b0;
    repeat (2) @(posedge i_Clk);
    for (int c = 0; c < n; c++) begin
      @(posedge i_Clk);
      #1;
      i_Reset  = rst[c];
      i_Switch = lvl[c];
      @(negedge i_Clk);
      ob_press[c]  = o_Press;
      ob_short[c]  = o_Short;
      ob_double[c] = o_Double;
      ob_long[c]   = o_Long;
      ob_rep[c]    = o_Repeat;
      ob_held[c]   = o_Held;
    end
  endtask

  function automatic int pulses(input logic a [MAXC], input int lo, input int hi);
    int k;
    k = 0;
    for (int i = lo; i < hi; i++) begin
      if (a[i] === 1'b1) k++;
    end
    return k;
  endfunction

  // Model works on press/gap run lengths rather than on FSM states
  task automatic compute_model();
    int   rises [$];
    logic p;
    int   r, h, f, g, idx;
    bit   second;
    for (int i = 0; i < MAXC; i++) begin
      ex_press[i] = 0; ex_short[i] = 0; ex_double[i] = 0; ex_long[i] = 0; ex_rep[i] = 0;
    end
    p = 1'b0;
    for (int c = 0; c < n; c++) begin
      if (lvl[c] && !p) rises.push_back(c);
      p = lvl[c];
    end
    second = 0;
    foreach (rises[i]) begin
      r = rises[i];
      h = 0;
      while (r + h < n && lvl[r + h]) h++;
      f = r + h;
      g = 0;
      while (f + g < n && !lvl[f + g]) g++;
      if (r + 1 < n) ex_press[r + 1] = 1;
      if (second) begin
        second = 0;
      end else if (h > LONG) begin
        idx = r + LONG + 1;
        if (idx < n) ex_long[idx] = 1;
`ifdef BUTTON_REPEAT_EN
        for (int k = 1; LONG + k * REP < h; k++) begin
          idx = r + LONG + 1 + k * REP;
          if (idx < n) ex_rep[idx] = 1;
        end
`endif
      end else if (f + g < n && g <= DBL) begin
        idx = f + g + 1;
        if (idx < n) ex_double[idx] = 1;
        second = 1;
      end else begin
        idx = f + DBL + 1;
        if (idx < n) ex_short[idx] = 1;
      end
    end
  endtask

  task automatic test_reset();
    logic [5:0] got;
    int k;
    clear_stim();
    for (int c = 0; c < 6; c++) begin
      rst[c] = 1'b1;
      lvl[c] = logic'(c % 2);
    end
    n = 6;
    add_seg(1, 5);
    add_seg(0, 3);
    add_seg(1, 3);
    add_seg(0, 14);
    run_stim();
    for (int c = 0; c <= 6; c++) begin
      got = {ob_press[c], ob_short[c], ob_double[c], ob_long[c], ob_rep[c], ob_held[c]};
      tests_run++;
      if (got !== 6'b0) begin
        tests_failed++;
        $display("FAIL reset_outputs cycle %0d: got %b required 000000", c, got);
      end
    end
    tests_run++;
    if (ob_held[7] !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_held: got %b required 1", ob_held[7]);
    end
    k = pulses(ob_press, 7, 15);
    tests_run++;
    if (k !== 0) begin
      tests_failed++;
      $display("FAIL reset_no_phantom_press: got %0d presses required 0", k);
    end
    tests_run++;
    if (ob_press[15] !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_rearm_press: got %b required 1", ob_press[15]);
    end
    tests_run++;
    if (ob_short[23] !== 1'b1 || pulses(ob_short, 0, n) !== 1) begin
      tests_failed++;
      $display("FAIL reset_rearm_short: got %b at 23 (%0d total) required 1 (1)",
               ob_short[23], pulses(ob_short, 0, n));
    end
  endtask

  task automatic test_short();
    clear_stim();
    add_seg(0, 2);
    add_seg(1, 3);
    add_seg(0, 15);
    run_stim();
    tests_run++;
    if (ob_press[3] !== 1'b1 || pulses(ob_press, 0, n) !== 1) begin
      tests_failed++;
      $display("FAIL short_press: got %b at 3, %0d total; required 1, 1", ob_press[3], pulses(ob_press, 0, n));
    end
    tests_run++;
    if (ob_short[11] !== 1'b1 || pulses(ob_short, 0, n) !== 1) begin
      tests_failed++;
      $display("FAIL short_pulse: got %b at 11, %0d total; required 1, 1", ob_short[11], pulses(ob_short, 0, n));
    end
    tests_run++;
    if (pulses(ob_double, 0, n) + pulses(ob_long, 0, n) + pulses(ob_rep, 0, n) !== 0) begin
      tests_failed++;
      $display("FAIL short_others: got %0d stray pulses required 0",
               pulses(ob_double, 0, n) + pulses(ob_long, 0, n) + pulses(ob_rep, 0, n));
    end
  endtask

  task automatic test_double();
    clear_stim();
    add_seg(0, 2);
    add_seg(1, 3);
    add_seg(0, 2);
    add_seg(1, 3);
    add_seg(0, 15);
    run_stim();
    tests_run++;
    if (ob_press[3] !== 1'b1 || ob_press[8] !== 1'b1 || pulses(ob_press, 0, n) !== 2) begin
      tests_failed++;
      $display("FAIL double_press: got %0d presses required 2 at 3 and 8", pulses(ob_press, 0, n));
    end
    tests_run++;
    if (ob_double[8] !== 1'b1 || pulses(ob_double, 0, n) !== 1) begin
      tests_failed++;
      $display("FAIL double_pulse: got %b at 8, %0d total; required 1, 1", ob_double[8], pulses(ob_double, 0, n));
    end
    tests_run++;
    if (pulses(ob_short, 0, n) + pulses(ob_long, 0, n) !== 0) begin
      tests_failed++;
      $display("FAIL double_others: got %0d short/long required 0", pulses(ob_short, 0, n) + pulses(ob_long, 0, n));
    end
  endtask

  task automatic test_long();
    int k;
    clear_stim();
    add_seg(0, 2);
    add_seg(1, 20);
    add_seg(0, 15);
    run_stim();
    tests_run++;
    if (ob_long[13] !== 1'b1 || pulses(ob_long, 0, n) !== 1) begin
      tests_failed++;
      $display("FAIL long_pulse: got %b at 13, %0d total; required 1, 1", ob_long[13], pulses(ob_long, 0, n));
    end
    tests_run++;
    if (pulses(ob_short, 0, n) + pulses(ob_double, 0, n) !== 0) begin
      tests_failed++;
      $display("FAIL long_no_click: got %0d short/double required 0", pulses(ob_short, 0, n) + pulses(ob_double, 0, n));
    end
    k = pulses(ob_rep, 0, n);
`ifdef BUTTON_REPEAT_EN
    tests_run++;
    if (ob_rep[17] !== 1'b1 || ob_rep[21] !== 1'b1 || k !== 2) begin
      tests_failed++;
      $display("FAIL long_repeat: got %0d repeats (%b@17 %b@21) required 2 at 17 and 21", k, ob_rep[17], ob_rep[21]);
    end
`else
    tests_run++;
    if (k !== 0) begin
      tests_failed++;
      $display("FAIL long_repeat_off: got %0d repeats required 0", k);
    end
`endif
  endtask

  task automatic test_boundaries();
    clear_stim();
    add_seg(0, 2);
    add_seg(1, 10);
    add_seg(0, 8);
    add_seg(1, 3);
    add_seg(0, 5);
    add_seg(1, 3);
    add_seg(0, 15);
    run_stim();
    tests_run++;
    if (pulses(ob_long, 0, n) !== 0) begin
      tests_failed++;
      $display("FAIL boundary_fall_at_limit_long: got %0d required 0", pulses(ob_long, 0, n));
    end
    tests_run++;
    if (ob_short[18] !== 1'b1 || pulses(ob_short, 0, n) !== 1) begin
      tests_failed++;
      $display("FAIL boundary_short: got %b at 18, %0d total; required 1, 1", ob_short[18], pulses(ob_short, 0, n));
    end
    tests_run++;
    if (ob_double[29] !== 1'b1 || pulses(ob_double, 0, n) !== 1) begin
      tests_failed++;
      $display("FAIL boundary_rise_at_expiry: got %b at 29, %0d total; required 1, 1", ob_double[29], pulses(ob_double, 0, n));
    end
    tests_run++;
    if (pulses(ob_press, 0, n) !== 3) begin
      tests_failed++;
      $display("FAIL boundary_press_count: got %0d required 3", pulses(ob_press, 0, n));
    end
  endtask

  task automatic test_reset_mid();
    clear_stim();
    add_seg(0, 2);
    add_seg(1, 3);
    add_seg(0, 15);
    rst[7] = 1'b1;
    rst[8] = 1'b1;
    add_seg(1, 3);
    add_seg(0, 15);
    run_stim();
    tests_run++;
    if (ob_short[29] !== 1'b1 || pulses(ob_short, 0, n) !== 1) begin
      tests_failed++;
      $display("FAIL reset_mid_short: got %b at 29, %0d total; required 1, 1", ob_short[29], pulses(ob_short, 0, n));
    end
    tests_run++;
    if (pulses(ob_double, 0, n) + pulses(ob_long, 0, n) !== 0 || ob_press[21] !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_mid_others: got %0d double/long, press@21=%b; required 0, 1",
               pulses(ob_double, 0, n) + pulses(ob_long, 0, n), ob_press[21]);
    end
  endtask

  task automatic test_random();
    logic [5:0] got, exp;
    logic held_exp;
    int presses;
    for (int s = 0; s < 10; s++) begin
      clear_stim();
      add_seg(0, $urandom_range(1, 3));
      presses = $urandom_range(3, 8);
      for (int p = 0; p < presses; p++) begin
        add_seg(1, $urandom_range(1, 24));
        add_seg(0, (p == presses - 1) ? 12 : $urandom_range(1, 9));
      end
      compute_model();
      run_stim();
      for (int c = 0; c < n; c++) begin
        held_exp = 1'b0;
        if (c > 0) held_exp = lvl[c - 1];
        got = {ob_press[c], ob_short[c], ob_double[c], ob_long[c], ob_rep[c], ob_held[c]};
        exp = {ex_press[c], ex_short[c], ex_double[c], ex_long[c], ex_rep[c], held_exp};
        tests_run++;
        if (got !== exp) begin
          tests_failed++;
          $display("FAIL random[%0d] cycle %0d: got p/s/d/l/r/h=%b required %b", s, c, got, exp);
        end
      end
    end
  endtask

  initial begin
    i_Reset  = 1'b1;
    i_Switch = 1'b0;
    test_reset();
    test_short();
    test_double();
    test_long();
    test_boundaries();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
